riscv_lsu_mem_stage: RTL and testbench



---
 rtl/riscv_lsu_mem_stage.sv | 196 +++++++++++++++++++
 tb/tb_riscv_lsu_mem_stage.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu_mem_stage.sv
// Load/store memory stage: aligns, enables and issues one data-cache access at a time, then hands the result to writeback.
// Latency: pass-through/fault 1 cycle, store 2 cycles, load 3 cycles (with zero-wait cache).
// Backpressure: valid/ready on both sides; in_ready drops while an operation is held or in flight.
module riscv_lsu_mem_stage #(
    parameter int XLEN = 64,
    localparam int NB = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_rd_addr,
    input  logic [2:0]      in_funct3,
    input  logic            in_is_load,
    input  logic            in_is_store,
    output logic            dc_req_valid,
    input  logic            dc_req_ready,
    output logic [XLEN-1:0] dc_req_addr,
    output logic            dc_req_we,
    output logic [NB-1:0]   dc_req_be,
    output logic [XLEN-1:0] dc_req_wdata,
    input  logic            dc_rsp_valid,
    input  logic [XLEN-1:0] dc_rsp_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [4:0]      out_rd_addr,
    output logic [XLEN-1:0] out_data,
    output logic            out_fault
);

    typedef enum logic [2:0] {IDLE, REQ, RSP, DONE, DRAIN} state_t;

    state_t          state;
    logic [2:0]      f3_q;
    logic [OFFW-1:0] off_q;

    logic [OFFW-1:0] in_off;
    logic            st_c;
    logic            ld_c;
    logic            mem_c;
    logic            misalign_c;
    logic            illegal_c;
    logic            fault_c;
    logic [NB-1:0]   be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext;

    // Accept only from an empty stage or one whose result is leaving this cycle.
    assign in_ready = ((state == IDLE) || ((state == DONE) && out_ready)) && !flush;

    // Decode the incoming operation: lane placement, alignment and legality.
    always_comb begin
        in_off     = in_addr[OFFW-1:0];
        st_c       = in_is_store;
        ld_c       = in_is_load & ~in_is_store;
        mem_c      = st_c | ld_c;
        misalign_c = 1'b0;
        be_c       = '0;
        case (in_funct3[1:0])
            2'b00:   be_c = NB'(1) << in_off;
            2'b01: begin
                misalign_c = in_addr[0];
                be_c       = NB'(3) << in_off;
            end
            2'b10: begin
                misalign_c = |in_addr[1:0];
                be_c       = NB'(15) << in_off;
            end
            default: begin
                misalign_c = |in_addr[2:0];
                be_c       = '1;
            end
        endcase
        illegal_c = 1'b0;
        if (ld_c)
            illegal_c = (in_funct3 == 3'b111) ||
                        ((XLEN == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));
        if (st_c)
            illegal_c = in_funct3[2] || ((XLEN == 32) && (in_funct3 == 3'b011));
        fault_c = mem_c && (misalign_c || illegal_c);
        wdata_c = in_wdata << {in_off, 3'b000};
    end

    // Bring the addressed lanes of the response down to bit 0 and extend by access type.
    always_comb begin
        shifted = dc_rsp_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = XLEN'($signed(shifted[7:0]));
            3'b001:  ext = XLEN'($signed(shifted[15:0]));
            3'b010:  ext = XLEN'($signed(shifted[31:0]));
            3'b100:  ext = XLEN'(shifted[7:0]);
            3'b101:  ext = XLEN'(shifted[15:0]);
            3'b110:  ext = XLEN'(shifted[31:0]);
            default: ext = shifted;
        endcase
    end

    // Stage controller; every cache request and writeback field is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            f3_q         <= '0;
            off_q        <= '0;
            dc_req_valid <= 1'b0;
            dc_req_addr  <= '0;
            dc_req_we    <= 1'b0;
            dc_req_be    <= '0;
            dc_req_wdata <= '0;
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_inst     <= '0;
            out_rd_addr  <= '0;
            out_data     <= '0;
            out_fault    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (flush) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else if ((state == IDLE) || out_ready) begin
                        if (in_valid) begin
                            out_pc      <= in_pc;
                            out_inst    <= in_inst;
                            out_rd_addr <= in_rd_addr;
                            out_fault   <= fault_c;
                            f3_q        <= in_funct3;
                            off_q       <= in_off;
                            if (!mem_c) begin
                                state     <= DONE;
                                out_valid <= 1'b1;
                                out_data  <= in_addr;
                            end else if (fault_c) begin
                                state     <= DONE;
                                out_valid <= 1'b1;
                                out_data  <= '0;
                            end else begin
                                state        <= REQ;
                                out_valid    <= 1'b0;
                                dc_req_valid <= 1'b1;
                                dc_req_addr  <= {in_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                                dc_req_we    <= st_c;
                                dc_req_be    <= be_c;
                                dc_req_wdata <= wdata_c;
                            end
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (dc_req_ready) begin
                        dc_req_valid <= 1'b0;
                        if (dc_req_we) begin
                            // A store that handshakes is committed even if flushed.
                            state     <= flush ? IDLE : DONE;
                            out_valid <= !flush;
                            out_data  <= '0;
                        end else begin
                            state <= flush ? DRAIN : RSP;
                        end
                    end else if (flush) begin
                        state        <= IDLE;
                        dc_req_valid <= 1'b0;
                    end
                end
                RSP: begin
                    if (dc_rsp_valid) begin
                        // A response coinciding with flush is consumed here, so no drain is needed.
                        state     <= flush ? IDLE : DONE;
                        out_valid <= !flush;
                        out_data  <= ext;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dc_rsp_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu_mem_stage.sv
// Scoreboard bench for riscv_lsu_mem_stage at XLEN=64 and XLEN=32.
module tb_riscv_lsu_mem_stage;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  be;
        logic [63:0] wdata;
    } req_t;

    logic clk, rst_n, flush;
    logic in_valid, in_ready, in_is_load, in_is_store;
    logic [63:0] in_pc, in_addr, in_wdata;
    logic [31:0] in_inst;
    logic [4:0]  in_rd_addr;
    logic [2:0]  in_funct3;
    logic dc_req_valid, dc_req_ready, dc_req_we, dc_rsp_valid;
    logic [63:0] dc_req_addr, dc_req_wdata, dc_rsp_rdata;
    logic [7:0]  dc_req_be;
    logic out_valid, out_ready, out_fault;
    logic [63:0] out_pc, out_data;
    logic [31:0] out_inst;
    logic [4:0]  out_rd_addr;

    logic        v32, r32, q_v32, q_r32, q_we32, rsp_v32, o_v32, o_f32;
    logic [31:0] a32, q_a32, q_wd32, rsp_d32, o_pc32, o_inst32, o_d32;
    logic [2:0]  f3_32;
    logic [3:0]  q_be32;
    logic [4:0]  o_rd32;

    exp_t q64[$];
    exp_t q32[$];
    req_t rq[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int req32_cnt = 0;
    int rsp_gap = 0;
    logic [63:0] rsp_data;

    riscv_lsu_mem_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd_addr(in_rd_addr), .in_funct3(in_funct3),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_we(dc_req_we), .dc_req_be(dc_req_be), .dc_req_wdata(dc_req_wdata),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_rdata(dc_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rd_addr(out_rd_addr), .out_data(out_data), .out_fault(out_fault)
    );

    riscv_lsu_mem_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v32), .in_ready(r32), .in_pc(32'h0000_0200), .in_inst(32'h0000_5003),
        .in_addr(a32), .in_wdata(32'h0), .in_rd_addr(5'd9), .in_funct3(f3_32),
        .in_is_load(1'b1), .in_is_store(1'b0),
        .dc_req_valid(q_v32), .dc_req_ready(q_r32), .dc_req_addr(q_a32),
        .dc_req_we(q_we32), .dc_req_be(q_be32), .dc_req_wdata(q_wd32),
        .dc_rsp_valid(rsp_v32), .dc_rsp_rdata(rsp_d32),
        .out_valid(o_v32), .out_ready(1'b1), .out_pc(o_pc32), .out_inst(o_inst32),
        .out_rd_addr(o_rd32), .out_data(o_d32), .out_fault(o_f32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic [63:0] pc, input logic [2:0] f3, input logic ld, input logic st,
                         input logic [63:0] addr, input logic [63:0] wd, input logic exp_out,
                         input logic [63:0] edata, input logic efault, input int lat);
        exp_t e;
        bit acc = 0;
        int t = 0;
        in_valid = 1'b1; in_pc = pc; in_inst = pc[31:0] ^ 32'h0000_0013; in_rd_addr = pc[6:2];
        in_funct3 = f3; in_is_load = ld; in_is_store = st; in_addr = addr; in_wdata = wd;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'(in_ready), 64'(1));
        else if (exp_out) begin
            e.pc = pc; e.inst = pc[31:0] ^ 32'h0000_0013; e.rd = pc[6:2];
            e.data = edata; e.fault = efault; e.lat = lat; e.acc = cyc;
            q64.push_back(e);
        end
    endtask

    task automatic push_req(input logic [63:0] addr, input logic we, input logic [7:0] be,
                            input logic [63:0] wd);
        req_t r;
        r.addr = addr; r.we = we; r.be = be; r.wdata = wd;
        rq.push_back(r);
    endtask

    task automatic settle();
        int t = 0;
        while ((q64.size() != 0 || rq.size() != 0 || q32.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (t >= 100) begin
            chk("settle_timeout", 64'(q64.size() + rq.size() + q32.size()), 64'(0));
            q64.delete(); rq.delete(); q32.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] edata, input logic efault);
        exp_t e;
        bit acc = 0;
        int t = 0;
        v32 = 1'b1; a32 = addr; f3_32 = f3;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = r32;
            @(posedge clk);
            #1;
            t++;
        end
        v32 = 1'b0;
        if (!acc) chk("accept32_timeout", 64'(r32), 64'(1));
        else begin
            e.pc = 64'h200; e.inst = 32'h0000_5003; e.rd = 5'd9;
            e.data = 64'(edata); e.fault = efault; e.lat = 0; e.acc = cyc;
            q32.push_back(e);
        end
    endtask

    // Writeback monitor: every cycle a result is offered it must match the head of the scoreboard.
    initial begin
        exp_t e;
        bit seen = 0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q64.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'(0));
                else begin
                    e = q64[0];
                    if (!seen) begin
                        seen = 1;
                        if (e.lat > 0) chk("latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
                    end
                    chk("out_data", out_data, e.data);
                    chk("out_fault", 64'(out_fault), 64'(e.fault));
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", 64'(out_inst), 64'(e.inst));
                    chk("out_rd", 64'(out_rd_addr), 64'(e.rd));
                    if (out_ready) begin
                        void'(q64.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    // Cache model: checks each offered request against expectations and answers loads.
    initial begin
        req_t r;
        dc_rsp_valid = 1'b0;
        dc_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && dc_req_valid) begin
                if (rq.size() == 0) chk("unexpected_req", 64'(dc_req_valid), 64'(0));
                else begin
                    r = rq[0];
                    chk("req_addr", dc_req_addr, r.addr);
                    chk("req_we", 64'(dc_req_we), 64'(r.we));
                    chk("req_be", 64'(dc_req_be), 64'(r.be));
                    if (r.we) chk("req_wdata", dc_req_wdata, r.wdata);
                    if (dc_req_ready) begin
                        void'(rq.pop_front());
                        hs_cnt++;
                        if (!dc_req_we) begin
                            @(posedge clk);
                            repeat (rsp_gap) @(posedge clk);
                            #1;
                            dc_rsp_valid = 1'b1;
                            dc_rsp_rdata = rsp_data;
                            @(posedge clk);
                            #1;
                            dc_rsp_valid = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // XLEN=32 cache and writeback monitor.
    initial begin
        exp_t e;
        q_r32 = 1'b1;
        rsp_v32 = 1'b0;
        rsp_d32 = '0;
        forever begin
            @(negedge clk);
            if (rst_n && o_v32) begin
                if (q32.size() == 0) chk("unexpected_out32", 64'(o_v32), 64'(0));
                else begin
                    e = q32.pop_front();
                    chk("out32_data", 64'(o_d32), e.data);
                    chk("out32_fault", 64'(o_f32), 64'(e.fault));
                end
            end
            if (rst_n && q_v32) begin
                req32_cnt++;
                chk("req32_be", 64'(q_be32), 64'(4'hC));
                chk("req32_addr", 64'(q_a32), 64'(0));
                @(posedge clk);
                #1;
                rsp_v32 = 1'b1;
                rsp_d32 = 32'hABCD_0000;
                @(posedge clk);
                #1;
                rsp_v32 = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int c0;
        int t;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; dc_req_ready = 1'b1;
        in_pc = '0; in_inst = '0; in_addr = '0; in_wdata = '0; in_rd_addr = '0; in_funct3 = '0;
        in_is_load = 1'b0; in_is_store = 1'b0; rsp_data = '0;
        v32 = 1'b0; a32 = '0; f3_32 = '0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_fault", 64'(out_fault), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_out_pc", out_pc, 64'(0));
        chk("rst_out_inst_rd", {27'(0), out_inst, out_rd_addr}, 64'(0));
        chk("rst_req_valid_we", {62'(0), dc_req_valid, dc_req_we}, 64'(0));
        chk("rst_req_be", 64'(dc_req_be), 64'(0));
        chk("rst_req_addr", dc_req_addr, 64'(0));
        chk("rst_req_wdata", dc_req_wdata, 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // LB sign extension with full latency measurement.
        rsp_data = 64'h0000_0000_8000_0000;
        push_req(64'h1000, 1'b0, 8'h08, 64'h0);
        issue(64'h100, 3'b000, 1, 0, 64'h1003, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FF80, 0, 3);
        settle();
        // LH and LHU at the top halfword, LWU at the upper word.
        rsp_data = 64'hBEEF_0000_0000_0000;
        push_req(64'h1000, 1'b0, 8'hC0, 64'h0);
        issue(64'h104, 3'b001, 1, 0, 64'h1006, 64'h0, 1, 64'hFFFF_FFFF_FFFF_BEEF, 0, 3);
        settle();
        push_req(64'h1000, 1'b0, 8'hC0, 64'h0);
        issue(64'h108, 3'b101, 1, 0, 64'h1006, 64'h0, 1, 64'h0000_0000_0000_BEEF, 0, 3);
        settle();
        rsp_data = 64'h8000_0001_0000_0000;
        push_req(64'h1000, 1'b0, 8'hF0, 64'h0);
        issue(64'h10C, 3'b110, 1, 0, 64'h1004, 64'h0, 1, 64'h0000_0000_8000_0001, 0, 3);
        settle();
        // SH lane placement.
        push_req(64'h2000, 1'b1, 8'hC0, 64'h1234_0000_0000_0000);
        issue(64'h110, 3'b001, 0, 1, 64'h2006, 64'h1234, 1, 64'h0, 0, 2);
        settle();
        // Misaligned LW and illegal store size: fault with no request.
        issue(64'h114, 3'b010, 1, 0, 64'h1002, 64'h0, 1, 64'h0, 1, 1);
        issue(64'h118, 3'b100, 0, 1, 64'h0010, 64'h55, 1, 64'h0, 1, 1);
        settle();

        // LD held off by the cache for 3 cycles.
        h0 = hs_cnt;
        dc_req_ready = 1'b0;
        rsp_data = 64'h8877_6655_4433_2211;
        push_req(64'h3008, 1'b0, 8'hFF, 64'h0);
        issue(64'h11C, 3'b011, 1, 0, 64'h3008, 64'h0, 1, 64'h8877_6655_4433_2211, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        dc_req_ready = 1'b1;
        settle();
        chk("ld_handshakes", 64'(hs_cnt - h0), 64'(1));

        // Flush while waiting for a load response; the late response is drained.
        rsp_gap = 2;
        h0 = hs_cnt;
        push_req(64'h4000, 1'b0, 8'hFF, 64'h0);
        issue(64'h120, 3'b011, 1, 0, 64'h4000, 64'h0, 0, 64'h0, 0, 0);
        t = 0;
        while (hs_cnt == h0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        chk("flush_ld_handshake", 64'(hs_cnt - h0), 64'(1));
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("drain_in_ready_0a", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("drain_in_ready_0b", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("drain_in_ready_1", 64'(in_ready), 64'(1));
        rsp_gap = 0;
        @(posedge clk);
        #1;

        // Flush of a stalled store: the request must be withdrawn.
        dc_req_ready = 1'b0;
        push_req(64'h5000, 1'b1, 8'h0F, 64'h0000_0000_CAFE_F00D);
        issue(64'h124, 3'b010, 0, 1, 64'h5000, 64'hCAFE_F00D, 0, 64'h0, 0, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_st_req_valid", 64'(dc_req_valid), 64'(0));
        rq.delete();
        dc_req_ready = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through at full rate.
        c0 = cyc;
        for (int i = 0; i < 4; i++)
            issue(64'h200 + 64'(4 * i), 3'b000, 0, 0, 64'hDEAD_BEEF_0000_0001 + 64'(i), 64'h0, 1,
                  64'hDEAD_BEEF_0000_0001 + 64'(i), 0, 1);
        chk("throughput_cycles", 64'(cyc - c0), 64'(4));
        settle();

        // Pass-through with writeback stalling on alternate cycles.
        fork
            begin
                for (int i = 0; i < 4; i++)
                    issue(64'h300 + 64'(4 * i), 3'b010, 0, 0, 64'h0000_7700_0000_0000 + 64'(i),
                          64'h0, 1, 64'h0000_7700_0000_0000 + 64'(i), 0, 0);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
                out_ready = 1'b1;
            end
        join
        settle();

        // XLEN=32: LWU is illegal, LHU extracts the upper halfword.
        issue32(32'h0, 3'b110, 32'h0, 1);
        issue32(32'h2, 3'b101, 32'h0000_ABCD, 0);
        settle();
        chk("req32_count", 64'(req32_cnt), 64'(1));
        chk("queues_empty", 64'(q64.size() + rq.size() + q32.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
